// File: rtl/smooth_pkg.sv
// Shared definitions for the smoothing-filter sequencer: FSM encoding,
// window-length table and flush/fill limits.
package smooth_pkg;

  typedef enum logic [1:0] {
    ST_FLUSH     = 2'd0,
    ST_IDLE      = 2'd1,
    ST_WAIT_TICK = 2'd2,
    ST_AWAIT     = 2'd3
  } state_t;

  localparam int unsigned FLUSH_LEN = 16;
  localparam int unsigned FILL_MAX  = 16;
  localparam int unsigned FILL_W    = 5;

  // Window length in samples, indexed by select (00=1, 01=2, 10=4, 11=16)
  localparam logic [3:0][FILL_W-1:0] WIN_LEN = {5'd16, 5'd4, 5'd2, 5'd1};

endpackage

// File: rtl/smooth_filter_ctrl_if.sv
// Sample-source and filter-side signals of the smoothing sequencer.
interface smooth_filter_ctrl_if #(
  parameter int unsigned DATA_W = 16
);
  logic              run;
  logic              flush;
  logic [1:0]        select_in;
  logic              sample_valid;
  logic [DATA_W-1:0] sample_data;
  logic              req_sample;
  logic [DATA_W-1:0] data_x;
  logic              data_update;
  logic [1:0]        select;
  logic              filt_enable_n;
  logic              smooth_valid;
  logic [4:0]        fill_count;
  logic              timeout_err;
  logic              busy;

  modport master (
    output run, flush, select_in, sample_valid, sample_data,
    input  req_sample, data_x, data_update, select, filt_enable_n,
           smooth_valid, fill_count, timeout_err, busy
  );

  modport slave (
    input  run, flush, select_in, sample_valid, sample_data,
    output req_sample, data_x, data_update, select, filt_enable_n,
           smooth_valid, fill_count, timeout_err, busy
  );
endinterface

// File: rtl/smooth_tick_gen.sv
// Free-running CLK_DIV divider with a terminal-count pulse and synchronous clear.
module smooth_tick_gen #(
  parameter int unsigned CLK_DIV = 50000
) (
  input  logic clock,
  input  logic i_rst,
  input  logic i_clr,
  output logic o_tc_c
);
  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

  logic [CNT_W-1:0] r_cnt;

  assign o_tc_c = (r_cnt == CNT_W'(CLK_DIV - 1));

  always_ff @(posedge clock) begin
    if (i_rst || i_clr || o_tc_c) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end
endmodule

// File: rtl/smooth_filter_ctrl.sv
// Sequencer for the 16-tap moving-average filter: paces sample requests,
// flushes the reset-less filter history and tracks window fill.
module smooth_filter_ctrl
  import smooth_pkg::*;
#(
  parameter int unsigned CLK_DIV = 50000,
  parameter int unsigned TIMEOUT = 1000,
  parameter int unsigned DATA_W  = 16
) (
  input  logic                 clock,
  input  logic                 reset,
  smooth_filter_ctrl_if.slave  bus
);
  localparam int unsigned TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t              r_state;
  logic [3:0]          r_flush_cnt;
  logic [TO_W-1:0]     r_to_cnt;
  logic                r_req_sample;
  logic [DATA_W-1:0]   r_data_x;
  logic                r_data_update;
  logic [1:0]          r_select;
  logic                r_filt_enable_n;
  logic                r_smooth_valid;
  logic [FILL_W-1:0]   r_fill_count;
  logic                r_timeout_err;
  logic                r_busy;

  logic                w_tick;
  logic                w_tick_clr;
  logic                w_flush_go;
  logic                w_accept;
  logic [FILL_W-1:0]   w_fill_nxt;
  logic [1:0]          w_sel_nxt;
  logic                w_valid_nxt;

  assign w_tick_clr = (r_state == ST_IDLE) || (r_state == ST_FLUSH);

  smooth_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .clock  (clock),
    .i_rst  (reset),
    .i_clr  (w_tick_clr),
    .o_tc_c (w_tick)
  );

  // Flush beats a simultaneous sample; valid looks at next-cycle fill/select
  always_comb begin
    w_flush_go = bus.flush && (r_state != ST_FLUSH);
    w_accept   = (r_state == ST_AWAIT) && bus.sample_valid && !bus.flush;
    w_fill_nxt = r_fill_count;
    if (r_state == ST_FLUSH) begin
      w_fill_nxt = '0;
    end else if (w_accept && (r_fill_count < FILL_W'(FILL_MAX))) begin
      w_fill_nxt = r_fill_count + FILL_W'(1);
    end
    w_sel_nxt   = (r_state == ST_FLUSH) ? r_select : bus.select_in;
    w_valid_nxt = (r_state != ST_FLUSH) && !w_flush_go &&
                  (w_fill_nxt >= WIN_LEN[w_sel_nxt]);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state         <= ST_FLUSH;
      r_flush_cnt     <= '0;
      r_to_cnt        <= '0;
      r_req_sample    <= 1'b0;
      r_data_x        <= '0;
      r_data_update   <= 1'b0;
      r_select        <= 2'b00;
      r_filt_enable_n <= 1'b1;
      r_smooth_valid  <= 1'b0;
      r_fill_count    <= '0;
      r_timeout_err   <= 1'b0;
      r_busy          <= 1'b1;
    end else begin
      r_req_sample    <= 1'b0;
      r_data_update   <= 1'b0;
      r_busy          <= 1'b0;
      r_filt_enable_n <= 1'b0;
      r_select        <= w_sel_nxt;
      r_fill_count    <= w_fill_nxt;
      r_smooth_valid  <= w_valid_nxt;

      case (r_state)
        ST_FLUSH: begin
          r_data_x        <= '0;
          r_data_update   <= 1'b1;
          r_busy          <= 1'b1;
          r_filt_enable_n <= 1'b1;
          r_flush_cnt     <= r_flush_cnt + 4'd1;
          if (r_flush_cnt == 4'(FLUSH_LEN - 1)) begin
            r_state <= bus.run ? ST_WAIT_TICK : ST_IDLE;
          end
        end
        ST_IDLE: begin
          if (w_flush_go) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
          end else if (bus.run) begin
            r_state <= ST_WAIT_TICK;
          end
        end
        ST_WAIT_TICK: begin
          if (w_flush_go) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
          end else if (!bus.run) begin
            r_state <= ST_IDLE;
          end else if (w_tick) begin
            r_req_sample <= 1'b1;
            r_to_cnt     <= '0;
            r_state      <= ST_AWAIT;
          end
        end
        ST_AWAIT: begin
          if (w_flush_go) begin
            r_state     <= ST_FLUSH;
            r_flush_cnt <= '0;
          end else if (w_accept) begin
            r_data_x      <= bus.sample_data;
            r_data_update <= 1'b1;
            r_state       <= bus.run ? ST_WAIT_TICK : ST_IDLE;
          end else if (!bus.run) begin
            r_state <= ST_IDLE;
          end else if (r_to_cnt == TO_W'(TIMEOUT)) begin
            r_timeout_err <= 1'b1;
            r_state       <= ST_WAIT_TICK;
          end else begin
            r_to_cnt <= r_to_cnt + TO_W'(1);
          end
        end
        default: r_state <= ST_FLUSH;
      endcase
    end
  end

  assign bus.req_sample    = r_req_sample;
  assign bus.data_x        = r_data_x;
  assign bus.data_update   = r_data_update;
  assign bus.select        = r_select;
  assign bus.filt_enable_n = r_filt_enable_n;
  assign bus.smooth_valid  = r_smooth_valid;
  assign bus.fill_count    = r_fill_count;
  assign bus.timeout_err   = r_timeout_err;
  assign bus.busy          = r_busy;

endmodule

// File: doc/smooth_filter_ctrl.md
Name: smooth_filter_ctrl

Overview:
- Sequencer in front of the 16-tap moving-average smoothing filter.
- Paces accelerometer sample requests, accepts returned samples, and drives the filter's data_x, data_update, select and enable inputs.
- The filter's shift register has no reset, so this block flushes it with zeros after reset and on demand.
- Tracks how many genuine samples are in the window and reports when the smoothed output is valid for the selected window size.

Parameters:
- CLK_DIV, 50000, clock cycles between sample requests. Legal range 4..2^20.
- TIMEOUT, 1000, cycles to wait for sample_valid after a request. Must be less than CLK_DIV - 2.
- DATA_W, 16, sample width; must match the filter lane width.

Ports:
- clock, in, 1, system clock, rising edge.
- reset, in, 1, synchronous, active-high.
- run, in, 1, level; 1 = periodic sampling active.
- flush, in, 1, one-cycle request to zero the filter history.
- select_in, in, 2, requested window: 00=1, 01=2, 10=4, 11=16 samples.
- sample_valid, in, 1, one-cycle strobe; sample_data is valid.
- sample_data, in, DATA_W, sample from the accelerometer reader.
- req_sample, out, 1, one-cycle pulse requesting a new sample.
- data_x, out, DATA_W, to filter data_x.
- data_update, out, 1, to filter data_update; one-cycle shift strobe.
- select, out, 2, to filter select.
- filt_enable_n, out, 1, to filter enable. 0 = filter computes; 1 = filter holds its output.
- smooth_valid, out, 1, filter output reflects a full window of genuine samples.
- fill_count, out, 5, genuine samples in the window, saturating at 16.
- timeout_err, out, 1, sticky; a request went unanswered.
- busy, out, 1, high while in FLUSH.

Behaviour:
- All outputs are registered. Reset values:
  - req_sample = 0, data_update = 0, data_x = 0, select = 00.
  - filt_enable_n = 1, smooth_valid = 0, fill_count = 0, timeout_err = 0, busy = 1.
  - State = FLUSH with flush counter = 0; tick and timeout counters = 0.
- A reset asserted mid-operation aborts any request or flush and restarts FLUSH.
- FSM states: FLUSH, IDLE, WAIT_TICK, AWAIT.
- FLUSH:
  - Drives data_x = 0 and data_update = 1 for 16 consecutive cycles; busy = 1, filt_enable_n = 1.
  - After the 16th strobe: fill_count = 0, busy = 0. Next state is WAIT_TICK if run = 1, else IDLE.
  - flush, run and sample_valid are ignored while in FLUSH.
- IDLE: tick counter held at 0. run = 1 moves to WAIT_TICK.
- WAIT_TICK:
  - Tick counter counts 0..CLK_DIV-1.
  - At terminal count: req_sample = 1 for one cycle, counter wraps to 0, timeout counter clears, state moves to AWAIT.
- AWAIT:
  - Tick counter keeps running.
  - sample_valid = 1: next cycle data_x = sample_data, data_update = 1, fill_count += 1 (saturating at 16). State returns to WAIT_TICK.
  - No sample_valid within TIMEOUT cycles: timeout_err is set, no update is issued, state returns to WAIT_TICK.
- sample_valid outside AWAIT is ignored and produces no data_update.
- run falling: from WAIT_TICK or AWAIT, go to IDLE. A sample already accepted still completes its update. fill_count and history are kept.
- flush pulse outside FLUSH: enter FLUSH on the next cycle. An outstanding AWAIT is abandoned; a late sample_valid is ignored.
- Simultaneous flush and sample_valid in AWAIT: flush wins and the sample is dropped.
- data_update is high in at most one cycle per accepted sample, except during FLUSH.
- select:
  - select <= select_in every cycle outside FLUSH; frozen during FLUSH.
  - History is not cleared on a window change.
- Valid logic:
  - Window length N = 1/2/4/16 for select 00/01/10/11.
  - smooth_valid = (fill_count >= N) and not FLUSH, registered. It updates in the same cycle that select or fill_count updates.
- filt_enable_n = 0 in all states except FLUSH.
- timeout_err clears only on reset.

Decomposition:
- Shared package smooth_pkg holds:
  - FSM state encoding (2-bit enum).
  - Window-length constant table indexed by select.
  - Flush length FLUSH_LEN = 16.
  - FILL_MAX = 16.
- One natural sub-module: smooth_tick_gen, the CLK_DIV counter with a terminal-count pulse and synchronous clear.

Test Plan:
- Reset held 2 cycles, then released with run = 0 -> busy = 1 and data_x = 0 for 16 cycles with 16 data_update strobes, then IDLE with fill_count = 0, smooth_valid = 0.
- CLK_DIV = 8, run = 1, sample_valid 3 cycles after each req_sample with data 0x0010, 0x0020 -> req_sample every 8 cycles. data_update follows valid by 1 cycle. fill_count goes 1, 2.
- select_in = 10 while feeding samples -> smooth_valid stays 0 at fill_count = 3 and rises with the 4th update. Switching to 11 drops smooth_valid; it rises again after fill_count reaches 16 and saturates there.
- TIMEOUT = 4, no sample_valid after a request -> timeout_err = 1 five cycles later, no data_update, next req_sample on schedule. A late sample_valid is ignored.
- flush pulse asserted in the same cycle as sample_valid in AWAIT -> no sample update, 16 zero strobes follow, fill_count = 0, smooth_valid = 0, select frozen during FLUSH.
